// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, branch redirect, data-memory handshake, load-use bubbles.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  ID_rs1Reg,
  input  logic [REG_W-1:0]  ID_rs2Reg,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic              EX_MemRead,
  input  logic [REG_W-1:0]  EX_rdReg,
  input  logic              MEM_Branch,
  input  logic              MEM_Jump,
  input  logic              MEM_zero,
  input  logic              MEM_s_less,
  input  logic              MEM_u_less,
  input  logic [2:0]        MEM_funct3,
  input  logic [ADDR_W-1:0] MEM_PCSum,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              dmem_ready,
  output logic              dmem_req,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_target
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t state, state_next;

  logic cond;
  logic taken;
  logic mem_acc;
  logic load_use;
  logic frozen;

  always_comb begin
    cond = 1'b0;
    case (MEM_funct3)
      3'b000:  cond = MEM_zero;
      3'b001:  cond = !MEM_zero;
      3'b100:  cond = MEM_s_less;
      3'b101:  cond = !MEM_s_less;
      3'b110:  cond = MEM_u_less;
      3'b111:  cond = !MEM_u_less;
      default: cond = 1'b0;
    endcase
  end

  assign taken    = MEM_Jump | (MEM_Branch & cond);
  assign mem_acc  = MEM_MemRead | MEM_MemWrite;
  assign load_use = EX_MemRead && (EX_rdReg != '0) &&
                    ((ID_use_rs1 && (ID_rs1Reg == EX_rdReg)) ||
                     (ID_use_rs2 && (ID_rs2Reg == EX_rdReg)));

  // Once waiting, only dmem_ready releases the freeze; in RUN a fresh access must be pending too.
  assign frozen = (state == MEM_WAIT) ? !dmem_ready : (mem_acc & !dmem_ready);

  assign pc_target = MEM_PCSum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_acc && !dmem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (dmem_ready)             state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Priority: reset, then memory freeze, then redirect, then load-use bubble.
  always_comb begin
    dmem_req     = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_flush  = 1'b1;
    ex_mem_flush = 1'b1;
    mem_wb_flush = 1'b1;
    pc_src       = 1'b0;
    if (rst_n) begin
      dmem_req     = mem_acc;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      if (frozen) begin
        mem_wb_flush = 1'b1;
      end else if (taken) begin
        pc_src       = 1'b1;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        id_ex_flush  = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Free-running wrap-around counters of PC stall cycles and redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
      if (pc_src)    flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences, randomized model check.
// Counter checks are included when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
  localparam int ADDR_W = 64;
  localparam int REG_W  = 5;

  // Output vector bit order: req, pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, ex_mem_f, mem_wb_f, pc_src
  localparam logic [9:0] NORM   = 10'b0_1111_0000_0;
  localparam logic [9:0] REDIR  = 10'b0_1111_1110_1;
  localparam logic [9:0] LDUSE  = 10'b0_0011_0100_0;
  localparam logic [9:0] FROZEN = 10'b0_0000_0001_0;
  localparam logic [9:0] RESETV = 10'b0_0000_1111_0;
  localparam logic [9:0] REQ    = 10'b1_0000_0000_0;

  logic              clk;
  logic              rst_n;
  logic [REG_W-1:0]  ID_rs1Reg, ID_rs2Reg, EX_rdReg;
  logic              ID_use_rs1, ID_use_rs2, EX_MemRead;
  logic              MEM_Branch, MEM_Jump, MEM_zero, MEM_s_less, MEM_u_less;
  logic [2:0]        MEM_funct3;
  logic [ADDR_W-1:0] MEM_PCSum;
  logic              MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic              dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src;
  logic [ADDR_W-1:0] pc_target;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]       stall_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int stall_m = 0;
  int flush_m = 0;
  bit in_wait_m = 0;

  pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1Reg(ID_rs1Reg), .ID_rs2Reg(ID_rs2Reg),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_MemRead(EX_MemRead), .EX_rdReg(EX_rdReg),
    .MEM_Branch(MEM_Branch), .MEM_Jump(MEM_Jump), .MEM_zero(MEM_zero),
    .MEM_s_less(MEM_s_less), .MEM_u_less(MEM_u_less),
    .MEM_funct3(MEM_funct3), .MEM_PCSum(MEM_PCSum),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_src(pc_src), .pc_target(pc_target)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [4:0]     rs1, rs2;
    logic           u1, u2, exr;
    logic [4:0]     exrd;
    logic           br, jmp, z, sl, ul;
    logic [2:0]     f3;
    logic           mrd, mwr, rdy;
    logic [9:0]     exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic exr, logic [4:0] exrd, logic br, logic jmp, logic z,
                              logic sl, logic ul, logic [2:0] f3, logic mrd, logic mwr,
                              logic rdy, logic [9:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exr = exr; v.exrd = exrd;
    v.br = br; v.jmp = jmp; v.z = z; v.sl = sl; v.ul = ul; v.f3 = f3;
    v.mrd = mrd; v.mwr = mwr; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [9:0] gotVec();
    return {dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src};
  endfunction

  // Reference: straight from the priority rules, with a single "waiting" flag for the memory freeze.
  function automatic logic [9:0] refModel(bit waiting);
    bit acc, busy, cond, taken, hazard;
    logic [9:0] r;
    if (!rst_n) return RESETV;
    acc  = MEM_MemRead || MEM_MemWrite;
    busy = (waiting || acc) && !dmem_ready;
    case (MEM_funct3)
      3'd0: cond = MEM_zero;
      3'd1: cond = !MEM_zero;
      3'd4: cond = MEM_s_less;
      3'd5: cond = !MEM_s_less;
      3'd6: cond = MEM_u_less;
      3'd7: cond = !MEM_u_less;
      default: cond = 0;
    endcase
    taken  = MEM_Jump || (MEM_Branch && cond);
    hazard = EX_MemRead && EX_rdReg != 0 &&
             ((ID_use_rs1 && ID_rs1Reg == EX_rdReg) || (ID_use_rs2 && ID_rs2Reg == EX_rdReg));
    if (busy)        r = FROZEN;
    else if (taken)  r = REDIR;
    else if (hazard) r = LDUSE;
    else             r = NORM;
    return acc ? (r | REQ) : r;
  endfunction

  task automatic setIdle();
    ID_rs1Reg = 0; ID_rs2Reg = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    EX_MemRead = 0; EX_rdReg = 0;
    MEM_Branch = 0; MEM_Jump = 0; MEM_zero = 0; MEM_s_less = 0; MEM_u_less = 0;
    MEM_funct3 = 0; MEM_MemRead = 0; MEM_MemWrite = 0; dmem_ready = 1;
  endtask

  task automatic applyStimulus(vec_t v);
    ID_rs1Reg = v.rs1; ID_rs2Reg = v.rs2; ID_use_rs1 = v.u1; ID_use_rs2 = v.u2;
    EX_MemRead = v.exr; EX_rdReg = v.exrd;
    MEM_Branch = v.br; MEM_Jump = v.jmp; MEM_zero = v.z; MEM_s_less = v.sl; MEM_u_less = v.ul;
    MEM_funct3 = v.f3; MEM_MemRead = v.mrd; MEM_MemWrite = v.mwr; dmem_ready = v.rdy;
  endtask

  task automatic checkValue(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Compare outputs for this cycle and advance the model's wait flag and counters.
  task automatic checkOutput(string name, logic [9:0] exp);
    #1;
    checks++;
    if (gotVec() !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%b expected=%b (req,pcw,ifw,idw,exw,iff,idf,exf,wbf,src)",
               name, gotVec(), exp);
    end
    checkValue({name, "/pc_target"}, pc_target, MEM_PCSum);
    if (rst_n) begin
      if (!exp[8]) stall_m++;
      if (exp[0])  flush_m++;
      in_wait_m = !exp[6];
    end else begin
      in_wait_m = 0;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 0; stall_m = 0; flush_m = 0;
    setIdle();
    checkOutput("reset", RESETV);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    MEM_PCSum = 64'h100;
    setIdle();
    checkOutput("reset_initial", RESETV);
    @(negedge clk);
    rst_n = 1;

    //        name            rs1 rs2 u1 u2 exr exrd br jmp z sl ul f3 mrd mwr rdy exp
    vecs.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM));
    vecs.push_back(mk("beq_taken",   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, REDIR));
    vecs.push_back(mk("beq_not",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, NORM));
    vecs.push_back(mk("f3_010",      0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 2, 0, 0, 1, NORM));
    vecs.push_back(mk("f3_011",      0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 3, 0, 0, 1, NORM));
    vecs.push_back(mk("bne_taken",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, REDIR));
    vecs.push_back(mk("bne_not",     0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, NORM));
    vecs.push_back(mk("blt_taken",   0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4, 0, 0, 1, REDIR));
    vecs.push_back(mk("bge_not",     0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5, 0, 0, 1, NORM));
    vecs.push_back(mk("bge_taken",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 1, REDIR));
    vecs.push_back(mk("bltu_taken",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 6, 0, 0, 1, REDIR));
    vecs.push_back(mk("bltu_not",    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 6, 0, 0, 1, NORM));
    vecs.push_back(mk("bgeu_taken",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7, 0, 0, 1, REDIR));
    vecs.push_back(mk("no_branch",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, NORM));
    vecs.push_back(mk("jump",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 1, REDIR));
    vecs.push_back(mk("lu_rs2",      0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, LDUSE));
    vecs.push_back(mk("lu_rd0",      0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM));
    vecs.push_back(mk("lu_unused",   0, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM));
    vecs.push_back(mk("lu_rs1",      7, 3, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, LDUSE));
    vecs.push_back(mk("nonload_dep", 7, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM));
    vecs.push_back(mk("jump_over_lu",0, 5, 0, 1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, REDIR));
    vecs.push_back(mk("ld_zero_wait",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NORM | REQ));
    vecs.push_back(mk("st_lu_nowait",0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, LDUSE | REQ));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Memory wait: three frozen cycles then advance on ready.
    applyReset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      setIdle();
      MEM_MemRead = (c < 4);
      dmem_ready  = (c >= 3);
      checkOutput($sformatf("memwait_c%0d", c), (c < 3) ? (FROZEN | REQ) : (c == 3) ? (NORM | REQ) : NORM);
    end
`ifdef PIPE_PERF_CNT_EN
    @(negedge clk);
    checkValue("memwait_stall_cnt", {32'd0, stall_cnt}, 64'd3);
    checkValue("memwait_flush_cnt", {32'd0, flush_cnt}, 64'd0);
`endif

    // Load-use during a wait: no bubble while frozen, one bubble on completion.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      setIdle();
      ID_rs2Reg = 9; ID_use_rs2 = 1; EX_rdReg = 9;
      EX_MemRead  = (c < 3);
      MEM_MemRead = (c < 3);
      dmem_ready  = (c >= 2);
      checkOutput($sformatf("wait_lu_c%0d", c), (c < 2) ? (FROZEN | REQ) : (c == 2) ? (LDUSE | REQ) : NORM);
    end

    // Jump together with a store: the redirect waits for the completion cycle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      setIdle();
      MEM_PCSum    = 64'h2000;
      MEM_Jump     = (c < 3);
      MEM_MemWrite = (c < 3);
      dmem_ready   = (c >= 2);
      checkOutput($sformatf("illegal_c%0d", c), (c < 2) ? (FROZEN | REQ) : (c == 2) ? (REDIR | REQ) : NORM);
    end

    // Reset asserted mid-wait, then idle with ready low must show RUN behaviour.
    @(negedge clk);
    setIdle(); MEM_MemRead = 1; dmem_ready = 0;
    checkOutput("rstwait_c0", FROZEN | REQ);
    @(negedge clk);
    checkOutput("rstwait_c1", FROZEN | REQ);
    #2;
    rst_n = 0; stall_m = 0; flush_m = 0;
    checkOutput("rstwait_abort", RESETV);
    @(negedge clk);
    checkOutput("rstwait_held", RESETV);
    @(negedge clk);
    rst_n = 1;
    setIdle(); dmem_ready = 0;
    checkOutput("rstwait_run", NORM);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ID_rs1Reg    = 5'($urandom_range(0, 3));
      ID_rs2Reg    = 5'($urandom_range(0, 3));
      EX_rdReg     = 5'($urandom_range(0, 3));
      ID_use_rs1   = 1'($urandom);
      ID_use_rs2   = 1'($urandom);
      EX_MemRead   = 1'($urandom);
      MEM_Branch   = 1'($urandom);
      MEM_Jump     = ($urandom_range(0, 7) == 0);
      MEM_zero     = 1'($urandom);
      MEM_s_less   = 1'($urandom);
      MEM_u_less   = 1'($urandom);
      MEM_funct3   = 3'($urandom);
      MEM_PCSum    = {$urandom, $urandom};
      MEM_MemRead  = ($urandom_range(0, 3) == 0);
      MEM_MemWrite = ($urandom_range(0, 5) == 0);
      dmem_ready   = 1'($urandom);
      checkOutput($sformatf("random_%0d", i), refModel(in_wait_m));
    end

`ifdef PIPE_PERF_CNT_EN
    @(negedge clk);
    setIdle();
    checkValue("final_stall_cnt", {32'd0, stall_cnt}, 64'(stall_m));
    checkValue("final_flush_cnt", {32'd0, flush_cnt}, 64'(flush_m));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
